// File: rtl/lsu_riscv_if.sv
// ============================================================================
// Module      : lsu_riscv_if
// Description : Core-side request/response and data-memory port bundle for
//               the load-store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_riscv_if;
  // Core side
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic        core_stall_o;
  logic [31:0] core_rd_o;
  logic        core_fault_o;
  // Memory side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  // LSU view
  modport master (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_stall_o, core_rd_o, core_fault_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  // Core + memory view
  modport slave (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_stall_o, core_rd_o, core_fault_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

`default_nettype wire

// File: rtl/lsu_riscv.sv
// ============================================================================
// Module      : lsu_riscv
// Description : Load-store unit. One aligned byte/half/word access per core
//               request over a ready-handshaked memory port; loads are sign-
//               or zero-extended, illegal accesses fault without touching
//               memory, optional BUSY timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_riscv #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  lsu_riscv_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_SZ_B  = 3'd0;
  localparam logic [2:0] c_SZ_H  = 3'd1;
  localparam logic [2:0] c_SZ_W  = 3'd2;
  localparam logic [2:0] c_SZ_BU = 3'd4;
  localparam logic [2:0] c_SZ_HU = 3'd5;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_lo;
  logic [31:0] r_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wd;
  logic [31:0] r_rd;
  logic        r_fault;

  logic        w_illegal;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_lane;
  logic [31:0] w_rd_ext;
  logic        w_timeout;

  // Legality, byte enables and replicated store data from the live core inputs
  always_comb begin
    w_illegal = 1'b0;
    w_be      = 4'b0000;
    w_wd      = bus.core_wd_i;
    case (bus.core_size_i)
      c_SZ_B:  w_illegal = 1'b0;
      c_SZ_H:  w_illegal = bus.core_addr_i[0];
      c_SZ_W:  w_illegal = (bus.core_addr_i[1:0] != 2'b00);
      c_SZ_BU: w_illegal = bus.core_we_i;
      c_SZ_HU: w_illegal = bus.core_we_i | bus.core_addr_i[0];
      default: w_illegal = 1'b1;
    endcase
    // BU/HU share the lane pattern of B/H, so decode on the low two bits
    case (bus.core_size_i[1:0])
      2'd0: begin
        w_be = 4'b0001 << bus.core_addr_i[1:0];
        w_wd = {4{bus.core_wd_i[7:0]}};
      end
      2'd1: begin
        w_be = 4'b0011 << bus.core_addr_i[1:0];
        w_wd = {2{bus.core_wd_i[15:0]}};
      end
      2'd2: begin
        w_be = 4'b1111;
        w_wd = bus.core_wd_i;
      end
      default: begin
        w_be = 4'b0000;
        w_wd = bus.core_wd_i;
      end
    endcase
  end

  // Lane selection and extension of the returned word using the latched offset
  always_comb begin
    w_lane = bus.mem_rd_i >> {r_lo, 3'b000};
    case (r_size)
      c_SZ_B:  w_rd_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      c_SZ_H:  w_rd_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      c_SZ_BU: w_rd_ext = {24'h0, w_lane[7:0]};
      c_SZ_HU: w_rd_ext = {16'h0, w_lane[15:0]};
      default: w_rd_ext = bus.mem_rd_i;
    endcase
  end

  // Timeout fires in the MEM_TIMEOUT-th BUSY cycle; counter is 0 in the first
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt == 32'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; ready takes priority over timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.core_req_i) w_next = w_illegal ? S_DONE : S_BUSY;
      S_BUSY: if (bus.mem_ready_i || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latching, memory port drive and load/fault result capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_size     <= 3'd0;
      r_lo       <= 2'd0;
      r_cnt      <= 32'd0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_be   <= 4'b0000;
      r_mem_addr <= 32'h0;
      r_mem_wd   <= 32'h0;
      r_rd       <= 32'h0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.core_req_i) begin
            r_we       <= bus.core_we_i;
            r_size     <= bus.core_size_i;
            r_lo       <= bus.core_addr_i[1:0];
            r_cnt      <= 32'd0;
            r_mem_we   <= bus.core_we_i;
            r_mem_be   <= w_be;
            r_mem_addr <= {bus.core_addr_i[31:2], 2'b00};
            r_mem_wd   <= w_wd;
            if (w_illegal) begin
              r_mem_req <= 1'b0;
              r_fault   <= 1'b1;
              r_rd      <= 32'h0;
            end else begin
              r_mem_req <= 1'b1;
              r_fault   <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (bus.mem_ready_i) begin
            r_mem_req <= 1'b0;
            r_fault   <= 1'b0;
            if (!r_we) r_rd <= w_rd_ext;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_fault   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_DONE: r_fault <= 1'b0;
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  assign bus.core_stall_o = bus.core_req_i & (r_state != S_DONE);
  assign bus.core_rd_o    = r_rd;
  assign bus.core_fault_o = r_fault;
  assign bus.mem_req_o    = r_mem_req;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_be_o     = r_mem_be;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wd_o     = r_mem_wd;

endmodule

`default_nettype wire

// File: tb/tb_lsu_riscv.sv
// ============================================================================
// Module      : tb_lsu_riscv
// Description : Scoreboard bench for lsu_riscv (MEM_TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_riscv;

  typedef struct {
    logic        mem;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        fault;
    int          stall;
  } exp_t;

  logic clk;
  logic rst_i;
  lsu_riscv_if bus();

  lsu_riscv #(.MEM_TIMEOUT(4)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_wait = -1;
  int   busy_n = 0;
  int   stall_cnt = 0;
  logic seen_mem = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory responder: ready in the (mem_wait+1)-th BUSY cycle, never if -1
  initial begin
    bus.mem_ready_i = 1'b0;
    bus.mem_rd_i    = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req_o === 1'b1) busy_n++;
      else busy_n = 0;
      bus.mem_ready_i = (bus.mem_req_o === 1'b1) && (busy_n == mem_wait + 1);
    end
  end

  // Monitor: memory port against queue head, result on stall release
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        stall_cnt = 0;
        seen_mem  = 1'b0;
      end else begin
        if (bus.mem_req_o === 1'b1 && q.size() != 0) begin
          seen_mem = 1'b1;
          chk("mem_we",   {31'h0, bus.mem_we_o}, {31'h0, q[0].we});
          chk("mem_be",   {28'h0, bus.mem_be_o}, {28'h0, q[0].be});
          chk("mem_addr", bus.mem_addr_o, q[0].addr);
          chk("mem_wd",   bus.mem_wd_o, q[0].wd);
        end
        if (bus.core_req_i === 1'b1 && bus.core_stall_o === 1'b1) begin
          stall_cnt++;
        end else if (bus.core_req_i === 1'b1 && bus.core_stall_o === 1'b0 && q.size() != 0) begin
          e = q.pop_front();
          chk("core_rd",    bus.core_rd_o, e.rd);
          chk("core_fault", {31'h0, bus.core_fault_o}, {31'h0, e.fault});
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
          chk("mem_issued", {31'h0, seen_mem}, {31'h0, e.mem});
          stall_cnt = 0;
          seen_mem  = 1'b0;
        end
      end
    end
  end

  // Issue one access at posedge+1 and return in the cycle after DONE
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdw, input int w,
                        input logic emem, input logic [3:0] ebe, input logic [31:0] eaddr,
                        input logic [31:0] ewd, input logic [31:0] erd, input logic efault,
                        input int estall);
    exp_t e;
    int k;
    e.mem = emem; e.we = we; e.be = ebe; e.addr = eaddr; e.wd = ewd;
    e.rd = erd; e.fault = efault; e.stall = estall;
    q.push_back(e);
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_rd_i    = rdw;
    mem_wait        = w;
    bus.core_req_i  = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (bus.core_stall_o === 1'b1 && k < 30);
    if (k >= 30) begin
      n_cmp++;
      n_err++;
      $display("FAIL access_timeout: got stall after %0d cycles expected release", k);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i           = 1'b1;
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'h0;
    bus.core_wd_i   = 32'h0;
    #12;
    chk("rst_mem_req",  {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_mem_we",   {31'h0, bus.mem_we_o}, 32'h0);
    chk("rst_mem_be",   {28'h0, bus.mem_be_o}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_wd",   bus.mem_wd_o, 32'h0);
    chk("rst_core_rd",  bus.core_rd_o, 32'h0);
    chk("rst_fault",    {31'h0, bus.core_fault_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // we size addr wd rdword wait | mem be maddr mwd rd fault stall
    access(0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0,  1, 4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80, 0, 2); // LB
    access(0, 3'd5, 32'h202, 32'h0, 32'hBEEF_0000, 3,  1, 4'b1100, 32'h200, 32'h0, 32'h0000_BEEF, 0, 5); // LHU
    access(1, 3'd0, 32'h7,   32'hAB, 32'h0, 0,         1, 4'b1000, 32'h4, 32'hABAB_ABAB, 32'h0000_BEEF, 0, 2); // SB
    access(1, 3'd2, 32'h8,   32'h1234_5678, 32'h0, 1,  1, 4'b1111, 32'h8, 32'h1234_5678, 32'h0000_BEEF, 0, 3); // SW
    access(0, 3'd2, 32'h6,   32'h0, 32'hFFFF_FFFF, 0,  0, 4'b0000, 32'h0, 32'h0, 32'h0, 1, 1); // LW misaligned
    access(1, 3'd1, 32'h1,   32'h0, 32'h0, 0,          0, 4'b0000, 32'h0, 32'h0, 32'h0, 1, 1); // SH misaligned
    access(0, 3'd3, 32'h0,   32'h0, 32'h0, 0,          0, 4'b0000, 32'h0, 32'h0, 32'h0, 1, 1); // size 3
    access(1, 3'd4, 32'h0,   32'h0, 32'h0, 0,          0, 4'b0000, 32'h0, 32'h0, 32'h0, 1, 1); // store BU
    access(0, 3'd1, 32'h2,   32'h0, 32'h8001_0000, 0,  1, 4'b1100, 32'h0, 32'h0, 32'hFFFF_8001, 0, 2); // LH
    access(0, 3'd4, 32'h1,   32'h0, 32'h0000_9A00, 0,  1, 4'b0010, 32'h0, 32'h0, 32'h0000_009A, 0, 2); // LBU
    access(1, 3'd1, 32'h2,   32'hCAFE_1357, 32'h0, 0,  1, 4'b1100, 32'h0, 32'h1357_1357, 32'h0000_009A, 0, 2); // SH
    access(0, 3'd2, 32'h10,  32'h0, 32'h5555_5555, -1, 1, 4'b1111, 32'h10, 32'h0, 32'h0000_009A, 1, 5); // timeout
    access(0, 3'd2, 32'h14,  32'h0, 32'hDEAD_BEEF, 3,  1, 4'b1111, 32'h14, 32'h0, 32'hDEAD_BEEF, 0, 5); // ready on 4th

    // Reset in the middle of BUSY
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h20;
    mem_wait        = -1;
    @(posedge clk);
    #1;
    chk("busy_mem_req", {31'h0, bus.mem_req_o}, 32'h1);
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_mem_req",  {31'h0, bus.mem_req_o}, 32'h0);
    chk("arst_mem_be",   {28'h0, bus.mem_be_o}, 32'h0);
    chk("arst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("arst_core_rd",  bus.core_rd_o, 32'h0);
    chk("arst_fault",    {31'h0, bus.core_fault_o}, 32'h0);
    bus.core_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    access(0, 3'd2, 32'h0, 32'h0, 32'h1122_3344, 0,  1, 4'b1111, 32'h0, 32'h0, 32'h1122_3344, 0, 2); // LW after reset
    bus.core_req_i = 1'b0;
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
